mem_arbiter: RTL and testbench

Two-port arbiter that shares the single data RAM between the instruction-fetch requester (r0) and the load/store requester (r1) of the MIPS pipeline. At most one RAM access is granted per cycle. The default favours r1; an ageing counter guarantees r0 is served within MAX_WAIT cycles. Read data returns registered, one cycle after grant, on the granted requester's response port. Misaligned accesses are rejected with an error response.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_age_ctr.sv | 38 +++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the RAM arbiter between instruction fetch (r0) and load/store (r1).
// Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
package mem_arb_pkg;

  typedef enum logic {
    PRIO_D  = 1'b0,
    FORCE_I = 1'b1
  } arb_state_t;

  localparam int WORD_ALIGN_BITS = 2;
  localparam int RSP_DATA_W      = 32;
  localparam int STAT_W          = 16;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [RSP_DATA_W-1:0] data;
  } arb_rsp_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb_age_ctr.sv
// Counts consecutive cycles r0 is denied while requesting; flags when the
// count is about to reach MAX_WAIT so the arbiter can force r0 next cycle.
module mem_arb_age_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic r0_req_i,
  input  logic r0_gnt_i,
  output logic reach_o
);

  localparam int AGE_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic [AGE_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (!r0_req_i || r0_gnt_i) begin
      age_d = '0;
    end else if (age_q != AGE_MAX) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  // Looking at the next value lets the state register enter FORCE_I on the same edge.
  assign reach_o = (age_d == AGE_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-RAM arbiter: r1 (load/store) has default priority, r0 (fetch)
// is forced after MAX_WAIT denials. Define MEM_ARB_STATS_EN for transfer statistics.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_rerr,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_rerr,
  output logic                  ram_write,
  output logic                  ram_read,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_r0_cnt,
  output logic [STAT_W-1:0]     stat_r1_cnt,
  output logic [STAT_W-1:0]     stat_force_cnt
`endif
);

  arb_state_t state_q, state_d;
  logic       force_next;

  logic                  sel_any;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_misaligned;
  logic [RSP_DATA_W-1:0] rsp_word;

  arb_rsp_t rsp0_q, rsp0_d;
  arb_rsp_t rsp1_q, rsp1_d;

  mem_arb_age_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_age (
    .clk      (clk),
    .rst      (rst),
    .r0_req_i (r0_req),
    .r0_gnt_i (r0_gnt),
    .reach_o  (force_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PRIO_D;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIO_D:  if (force_next) state_d = FORCE_I;
      FORCE_I: if (!r0_req || r0_gnt) state_d = PRIO_D;
      default: state_d = PRIO_D;
    endcase
  end

  // When the favoured requester is idle, the other one takes the slot.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (state_q == FORCE_I) begin
      if (r0_req)      r0_gnt = 1'b1;
      else if (r1_req) r1_gnt = 1'b1;
    end else begin
      if (r1_req)      r1_gnt = 1'b1;
      else if (r0_req) r0_gnt = 1'b1;
    end
  end

  always_comb begin
    sel_any   = r0_gnt | r1_gnt;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (r0_gnt) begin
      sel_we    = r0_we;
      sel_addr  = r0_addr;
      sel_wdata = r0_wdata;
    end else if (r1_gnt) begin
      sel_we    = r1_we;
      sel_addr  = r1_addr;
      sel_wdata = r1_wdata;
    end
    sel_misaligned = |sel_addr[WORD_ALIGN_BITS-1:0];
  end

  // Misaligned accesses are granted so the requester can move on, but never reach the RAM.
  assign ram_write = sel_any & ~sel_misaligned & sel_we;
  assign ram_read  = sel_any & ~sel_misaligned & ~sel_we;
  assign ram_addr  = sel_addr;
  assign ram_wdata = sel_wdata;

  always_comb begin
    rsp_word = ram_read ? RSP_DATA_W'(ram_rdata) : '0;
    rsp0_d   = '0;
    rsp1_d   = '0;
    if (r0_gnt) begin
      rsp0_d.valid = 1'b1;
      rsp0_d.err   = sel_misaligned;
      rsp0_d.data  = rsp_word;
    end
    if (r1_gnt) begin
      rsp1_d.valid = 1'b1;
      rsp1_d.err   = sel_misaligned;
      rsp1_d.data  = rsp_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_q <= '0;
      rsp1_q <= '0;
    end else begin
      rsp0_q <= rsp0_d;
      rsp1_q <= rsp1_d;
    end
  end

  assign r0_rvalid = rsp0_q.valid;
  assign r0_rerr   = rsp0_q.err;
  assign r0_rdata  = DATA_WIDTH'(rsp0_q.data);
  assign r1_rvalid = rsp1_q.valid;
  assign r1_rerr   = rsp1_q.err;
  assign r1_rdata  = DATA_WIDTH'(rsp1_q.data);

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_r0_q, stat_r1_q, stat_force_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_r0_q    <= '0;
      stat_r1_q    <= '0;
      stat_force_q <= '0;
    end else begin
      if (r0_gnt) stat_r0_q <= sat_inc(stat_r0_q);
      if (r1_gnt) stat_r1_q <= sat_inc(stat_r1_q);
      if (state_q == PRIO_D && state_d == FORCE_I) stat_force_q <= sat_inc(stat_force_q);
    end
  end

  assign stat_r0_cnt    = stat_r0_q;
  assign stat_r1_cnt    = stat_r1_q;
  assign stat_force_cnt = stat_force_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural RAM on the ram_* port.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_req = 1'b0, r0_we = 1'b0;
  logic [9:0]  r0_addr = '0;
  logic [31:0] r0_wdata = '0;
  logic        r0_gnt, r0_rvalid, r0_rerr;
  logic [31:0] r0_rdata;
  logic        r1_req = 1'b0, r1_we = 1'b0;
  logic [9:0]  r1_addr = '0;
  logic [31:0] r1_wdata = '0;
  logic        r1_gnt, r1_rvalid, r1_rerr;
  logic [31:0] r1_rdata;
  logic        ram_write, ram_read;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_r0_cnt, stat_r1_cnt, stat_force_cnt;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clk) if (ram_write) mem[ram_addr[9:2]] <= ram_wdata;

  mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_rerr(r0_rerr),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_rerr(r1_rerr),
    .ram_write(ram_write), .ram_read(ram_read), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_r0_cnt(stat_r0_cnt), .stat_r1_cnt(stat_r1_cnt), .stat_force_cnt(stat_force_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;

    // Reset state
    #2;
    chk("rst_r0_rvalid", {31'b0, r0_rvalid}, 32'd0);
    chk("rst_r1_rvalid", {31'b0, r1_rvalid}, 32'd0);
    chk("rst_r1_rdata", r1_rdata, 32'd0);
    chk("rst_gnt", {30'b0, r0_gnt, r1_gnt}, 32'd0);
    chk("rst_ram_ctl", {30'b0, ram_write, ram_read}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // r1 write then read @0
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 10'd0; r1_wdata = 32'hDEADBEEF;
    #1;
    chk("t1_wr_gnt", {30'b0, r0_gnt, r1_gnt}, 32'd1);
    chk("t1_wr_ram", {30'b0, ram_write, ram_read}, 32'd2);
    chk("t1_wr_wdata", ram_wdata, 32'hDEADBEEF);
    step();
    r1_we = 1'b0;
    #1;
    chk("t1_wr_rsp", {31'b0, r1_rvalid}, 32'd1);
    chk("t1_wr_rdata", r1_rdata, 32'd0);
    chk("t1_rd_gnt", {31'b0, r1_gnt}, 32'd1);
    chk("t1_rd_ram", {30'b0, ram_write, ram_read}, 32'd1);
    step();
    r1_req = 1'b0;
    #1;
    chk("t1_rd_rvalid", {31'b0, r1_rvalid}, 32'd1);
    chk("t1_rd_rdata", r1_rdata, 32'hDEADBEEF);
    chk("t1_rd_rerr", {31'b0, r1_rerr}, 32'd0);
    chk("t1_r0_quiet", {31'b0, r0_rvalid}, 32'd0);
    step();
    chk("t1_rvalid_pulse", {31'b0, r1_rvalid}, 32'd0);

    // Ageing: both request continuously; grants as {r0_gnt, r1_gnt}
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'h10;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'h14;
    for (int c = 0; c < 7; c++) begin
      #1;
      chk($sformatf("t2_gnt_c%0d", c), {30'b0, r0_gnt, r1_gnt}, (c == 4) ? 32'd2 : 32'd1);
      step();
    end
    r0_req = 1'b0; r1_req = 1'b0;
    step();
    step();
`ifdef MEM_ARB_STATS_EN
    chk("t2_force_cnt", {16'b0, stat_force_cnt}, 32'd1);
    chk("t2_r0_cnt", {16'b0, stat_r0_cnt}, 32'd1);
    chk("t2_r1_cnt", {16'b0, stat_r1_cnt}, 32'd8);
`endif

    // r0 write @4, then r1 read @4 right after
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'd4; r0_wdata = 32'hCAFEBABE;
    #1;
    chk("t3_r0_gnt", {30'b0, r0_gnt, r1_gnt}, 32'd2);
    step();
    r0_req = 1'b0; r0_we = 1'b0;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'd4;
    #1;
    chk("t3_r0_wr_rsp", {31'b0, r0_rvalid}, 32'd1);
    chk("t3_r0_wr_rdata", r0_rdata, 32'd0);
    step();
    r1_req = 1'b0;
    #1;
    chk("t3_r1_rvalid", {31'b0, r1_rvalid}, 32'd1);
    chk("t3_r1_rdata", r1_rdata, 32'hCAFEBABE);
    step();

    // Misaligned read @6 and misaligned write @6
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'd6;
    #1;
    chk("t4_gnt", {31'b0, r1_gnt}, 32'd1);
    chk("t4_ram_ctl", {30'b0, ram_write, ram_read}, 32'd0);
    step();
    r1_we = 1'b1; r1_wdata = 32'h1234_5678;
    #1;
    chk("t4_rvalid", {31'b0, r1_rvalid}, 32'd1);
    chk("t4_rerr", {31'b0, r1_rerr}, 32'd1);
    chk("t4_rdata", r1_rdata, 32'd0);
    chk("t4_wr_ram_ctl", {30'b0, ram_write, ram_read}, 32'd0);
    step();
    r1_we = 1'b0; r1_addr = 10'd4;
    #1;
    chk("t4_wr_rerr", {30'b0, r1_rvalid, r1_rerr}, 32'd3);
    step();
    r1_req = 1'b0;
    #1;
    chk("t4_ram_intact", r1_rdata, 32'hCAFEBABE);
    chk("t4_ram_intact_err", {31'b0, r1_rerr}, 32'd0);
    step();

    // Reset right after a read is accepted drops the response
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'd0;
    step();
    r1_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rvalid", {31'b0, r1_rvalid}, 32'd0);
    chk("t5_rdata", r1_rdata, 32'd0);
    chk("t5_outs", {28'b0, r0_gnt, r1_gnt, ram_write, ram_read}, 32'd0);
    step();
    chk("t5_rvalid_hold", {31'b0, r1_rvalid}, 32'd0);
`ifdef MEM_ARB_STATS_EN
    chk("t5_stats", {stat_r0_cnt, stat_force_cnt}, 32'd0);
`endif
    rst = 1'b0;
    step();
    r1_req = 1'b1; r1_addr = 10'd0;
    #1;
    chk("t5_post_gnt", {31'b0, r1_gnt}, 32'd1);
    step();
    r1_req = 1'b0;
    #1;
    chk("t5_post_rvalid", {31'b0, r1_rvalid}, 32'd1);
    chk("t5_post_rdata", r1_rdata, 32'hDEADBEEF);
    step();

    // Back-to-back r0 reads @0, @4, @8
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'd0;
    #1;
    chk("t6_gnt", {31'b0, r0_gnt}, 32'd1);
    step();
    r0_addr = 10'd4;
    #1;
    chk("t6_rv0", {31'b0, r0_rvalid}, 32'd1);
    chk("t6_rd0", r0_rdata, 32'hDEADBEEF);
    step();
    r0_addr = 10'd8;
    #1;
    chk("t6_rv1", {31'b0, r0_rvalid}, 32'd1);
    chk("t6_rd1", r0_rdata, 32'hCAFEBABE);
    step();
    r0_req = 1'b0;
    #1;
    chk("t6_rv2", {31'b0, r0_rvalid}, 32'd1);
    chk("t6_rd2", r0_rdata, 32'hA500_0002);
    step();
    chk("t6_rv_end", {31'b0, r0_rvalid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
